// File: rtl/sync_fifo_param_if.sv
// Purpose: handshake/data bundle between a producer/consumer pair and sync_fifo_param.
// Latency: none (wires only).
// Backpressure: none here; the FIFO reports full/empty and sticky error flags.
// Ports: master drives data/wrreq/rdreq; slave (the FIFO) drives q, usedw and flags.
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] data;
    logic             wrreq;
    logic             rdreq;
    logic [WIDTH-1:0] q;
    logic [AW:0]      usedw;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;

    modport master (
        output data, wrreq, rdreq,
        input  q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  data, wrreq, rdreq,
        output q, usedw, empty, full, almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Purpose: parametrised single-clock FIFO with watermarks, show-ahead option and sticky errors.
// Latency: write visible (empty low) 1 edge later; normal-mode q 1 edge after rdreq, show-ahead q = head word.
// Backpressure: none; writes while full (no read) and reads while empty are dropped and flagged sticky.
// Ports: clock, aclr_n (async active-low), sclr (sync clear), bus (slave modport: data/wrreq/rdreq in, q/usedw/flags out).
module sync_fifo_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter int SHOW_AHEAD = 0
) (
    input  logic                clock,
    input  logic                aclr_n,
    input  logic                sclr,
    sync_fifo_param_if.slave    bus
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             udf;
    logic             is_empty;
    logic             is_full;
    logic             rd_ok;
    logic             wr_ok;

    assign is_empty = (cnt == '0);
    assign is_full  = (cnt == CNT_W'(DEPTH));

    // A write into a full FIFO is still accepted when a read frees a slot on the same edge.
    assign rd_ok = bus.rdreq & ~is_empty;
    assign wr_ok = bus.wrreq & (~is_full | bus.rdreq);

    // Storage is never cleared; pointers define what is valid.
    always_ff @(posedge clock) begin
        if (aclr_n && !sclr && wr_ok) begin
            mem[wp] <= bus.data;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else if (sclr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so increment wraps DEPTH-1 -> 0 with no bubble.
            if (wr_ok) begin
                wp <= wp + 1'b1;
            end
            if (rd_ok) begin
                rp <= rp + 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + 1'b1;
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - 1'b1;
            end
            if (bus.wrreq && is_full && !bus.rdreq) begin
                ovf <= 1'b1;
            end
            if (bus.rdreq && is_empty) begin
                udf <= 1'b1;
            end
        end
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Head word is presented directly; meaningless while empty.
            assign bus.q = mem[rp];
        end else begin : g_normal
            logic [WIDTH-1:0] q_r;

            always_ff @(posedge clock or negedge aclr_n) begin
                if (!aclr_n) begin
                    q_r <= '0;
                end else if (sclr) begin
                    q_r <= '0;
                end else if (rd_ok) begin
                    q_r <= mem[rp];
                end
            end

            assign bus.q = q_r;
        end
    endgenerate

    assign bus.usedw        = cnt;
    assign bus.empty        = is_empty;
    assign bus.full         = is_full;
    assign bus.almost_empty = (cnt <= CNT_W'(AE_LEVEL));
    assign bus.almost_full  = (cnt >= CNT_W'(AF_LEVEL));
    assign bus.overflow     = ovf;
    assign bus.underflow    = udf;
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
    logic clock  = 1'b0;
    logic aclr_n = 1'b1;
    logic sclr_a = 1'b0;
    logic sclr_b = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // Default instance: 8 x 16, normal read mode.
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) ia ();
    sync_fifo_param dut_a (
        .clock  (clock),
        .aclr_n (aclr_n),
        .sclr   (sclr_a),
        .bus    (ia)
    );

    // Show-ahead instance: 12 x 8 with AE_LEVEL=3, AF_LEVEL=5.
    sync_fifo_param_if #(.WIDTH(12), .DEPTH(8)) ib ();
    sync_fifo_param #(
        .WIDTH(12), .DEPTH(8), .AF_LEVEL(5), .AE_LEVEL(3), .SHOW_AHEAD(1)
    ) dut_b (
        .clock  (clock),
        .aclr_n (aclr_n),
        .sclr   (sclr_b),
        .bus    (ib)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic       sc;
        logic [7:0] d;
        logic [7:0] q;
        logic [4:0] uw;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t vt[10];
    logic [7:0] mq[$];
    logic [7:0] last_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic a_cyc(input logic wr, input logic rd, input logic [7:0] d);
        ia.wrreq = wr;
        ia.rdreq = rd;
        ia.data  = d;
        tick();
        ia.wrreq = 1'b0;
        ia.rdreq = 1'b0;
    endtask

    task automatic b_cyc(input logic wr, input logic rd, input logic [11:0] d);
        ib.wrreq = wr;
        ib.rdreq = rd;
        ib.data  = d;
        tick();
        ib.wrreq = 1'b0;
        ib.rdreq = 1'b0;
    endtask

    initial begin
        ia.wrreq = 1'b0; ia.rdreq = 1'b0; ia.data = '0;
        ib.wrreq = 1'b0; ib.rdreq = 1'b0; ib.data = '0;

        //                wr rd sc  data     q      uw  emp ful ae af ovf udf
        vt[0] = '{1'b1, 1'b0, 1'b0, 8'h56, 8'h00, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 8'hAA, 8'h00, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3] = '{1'b1, 1'b0, 1'b0, 8'hAA, 8'h00, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h56, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hAA, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hAA, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'hAA, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[9] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Asynchronous reset asserted mid-cycle, checked before any clock edge.
        #3 aclr_n = 1'b0;
        #1;
        chk("rst.q",     32'(ia.q), 32'h0);
        chk("rst.usedw", 32'(ia.usedw), 32'd0);
        chk("rst.empty", 32'(ia.empty), 32'd1);
        chk("rst.full",  32'(ia.full), 32'd0);
        chk("rst.ae",    32'(ia.almost_empty), 32'd1);
        chk("rst.af",    32'(ia.almost_full), 32'd0);
        chk("rst.ovf",   32'(ia.overflow), 32'd0);
        chk("rst.udf",   32'(ia.underflow), 32'd0);
        chk("rst_b.ae",  32'(ib.almost_empty), 32'd1);
        chk("rst_b.af",  32'(ib.almost_full), 32'd0);
        @(negedge clock);
        aclr_n = 1'b1;

        // Basic fill/drain, underflow on empty read, sync clear.
        for (int i = 0; i < 10; i++) begin
            ia.wrreq = vt[i].wr;
            ia.rdreq = vt[i].rd;
            ia.data  = vt[i].d;
            sclr_a   = vt[i].sc;
            tick();
            ia.wrreq = 1'b0;
            ia.rdreq = 1'b0;
            sclr_a   = 1'b0;
            chk($sformatf("v%0d.q", i),     32'(ia.q), 32'(vt[i].q));
            chk($sformatf("v%0d.usedw", i), 32'(ia.usedw), 32'(vt[i].uw));
            chk($sformatf("v%0d.empty", i), 32'(ia.empty), 32'(vt[i].emp));
            chk($sformatf("v%0d.full", i),  32'(ia.full), 32'(vt[i].ful));
            chk($sformatf("v%0d.ae", i),    32'(ia.almost_empty), 32'(vt[i].ae));
            chk($sformatf("v%0d.af", i),    32'(ia.almost_full), 32'(vt[i].af));
            chk($sformatf("v%0d.ovf", i),   32'(ia.overflow), 32'(vt[i].ovf));
            chk($sformatf("v%0d.udf", i),   32'(ia.underflow), 32'(vt[i].udf));
        end

        // Full boundary and overflow.
        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b1, 1'b0, 8'(8'h10 + i));
            chk($sformatf("fill%0d.usedw", i), 32'(ia.usedw), 32'(i + 1));
            chk($sformatf("fill%0d.af", i),    32'(ia.almost_full), 32'((i + 1) >= 14));
            chk($sformatf("fill%0d.full", i),  32'(ia.full), 32'((i + 1) == 16));
        end
        a_cyc(1'b1, 1'b0, 8'hEE);
        chk("ovf.flag",  32'(ia.overflow), 32'd1);
        chk("ovf.usedw", 32'(ia.usedw), 32'd16);
        chk("ovf.full",  32'(ia.full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b0, 1'b1, 8'h00);
            chk($sformatf("drain%0d.q", i), 32'(ia.q), 32'(8'(8'h10 + i)));
        end
        chk("drain.empty",  32'(ia.empty), 32'd1);
        chk("drain.sticky", 32'(ia.overflow), 32'd1);
        sclr_a = 1'b1;
        tick();
        sclr_a = 1'b0;
        chk("sclr1.ovf", 32'(ia.overflow), 32'd0);

        // Simultaneous read/write at full across pointer wrap.
        mq.delete();
        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b1, 1'b0, 8'(8'h20 + i));
            mq.push_back(8'(8'h20 + i));
        end
        for (int k = 0; k < 20; k++) begin
            a_cyc(1'b1, 1'b1, 8'(8'h40 + k));
            mq.push_back(8'(8'h40 + k));
            chk($sformatf("sim%0d.q", k),     32'(ia.q), 32'(mq.pop_front()));
            chk($sformatf("sim%0d.full", k),  32'(ia.full), 32'd1);
            chk($sformatf("sim%0d.usedw", k), 32'(ia.usedw), 32'd16);
            chk($sformatf("sim%0d.ovf", k),   32'(ia.overflow), 32'd0);
        end
        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b0, 1'b1, 8'h00);
            last_q = mq.pop_front();
            chk($sformatf("wrapdrain%0d.q", i), 32'(ia.q), 32'(last_q));
        end
        chk("wrapdrain.empty", 32'(ia.empty), 32'd1);

        // Both requests while empty: write lands, read rejected.
        a_cyc(1'b1, 1'b1, 8'h77);
        chk("bothempty.usedw", 32'(ia.usedw), 32'd1);
        chk("bothempty.udf",   32'(ia.underflow), 32'd1);
        chk("bothempty.q",     32'(ia.q), 32'(last_q));

        // Sync clear with 6 stored words and a concurrent write.
        for (int i = 0; i < 5; i++) begin
            a_cyc(1'b1, 1'b0, 8'(8'h60 + i));
        end
        chk("presclr.usedw", 32'(ia.usedw), 32'd6);
        sclr_a   = 1'b1;
        ia.wrreq = 1'b1;
        ia.data  = 8'h99;
        tick();
        sclr_a   = 1'b0;
        ia.wrreq = 1'b0;
        chk("sclr.usedw", 32'(ia.usedw), 32'd0);
        chk("sclr.empty", 32'(ia.empty), 32'd1);
        chk("sclr.ovf",   32'(ia.overflow), 32'd0);
        chk("sclr.udf",   32'(ia.underflow), 32'd0);
        chk("sclr.q",     32'(ia.q), 32'h0);

        // Async reset mid-transfer discards stored words.
        a_cyc(1'b1, 1'b0, 8'h31);
        a_cyc(1'b1, 1'b0, 8'h32);
        a_cyc(1'b1, 1'b0, 8'h33);
        a_cyc(1'b0, 1'b1, 8'h00);
        chk("pre_arst.q",     32'(ia.q), 32'h31);
        chk("pre_arst.usedw", 32'(ia.usedw), 32'd2);
        #2 aclr_n = 1'b0;
        #1;
        chk("arst.q",     32'(ia.q), 32'h0);
        chk("arst.usedw", 32'(ia.usedw), 32'd0);
        chk("arst.empty", 32'(ia.empty), 32'd1);
        @(negedge clock);
        aclr_n = 1'b1;
        a_cyc(1'b1, 1'b0, 8'h5A);
        chk("post_arst.usedw", 32'(ia.usedw), 32'd1);
        a_cyc(1'b0, 1'b1, 8'h00);
        chk("post_arst.q",     32'(ia.q), 32'h5A);
        chk("post_arst.empty", 32'(ia.empty), 32'd1);

        // Show-ahead: head word visible right after the write edge.
        b_cyc(1'b1, 1'b0, 12'hABC);
        chk("sa.q0",     32'(ib.q), 32'hABC);
        chk("sa.empty0", 32'(ib.empty), 32'd0);
        b_cyc(1'b1, 1'b0, 12'h123);
        chk("sa.q1",     32'(ib.q), 32'hABC);
        chk("sa.usedw1", 32'(ib.usedw), 32'd2);
        b_cyc(1'b0, 1'b1, 12'h000);
        chk("sa.q2",     32'(ib.q), 32'h123);
        chk("sa.usedw2", 32'(ib.usedw), 32'd1);
        b_cyc(1'b0, 1'b1, 12'h000);
        chk("sa.empty3", 32'(ib.empty), 32'd1);
        chk("sa.udf3",   32'(ib.underflow), 32'd0);

        // Watermarks AE=3, AF=5 on depth 8, stepping up then down.
        for (int n = 1; n <= 8; n++) begin
            b_cyc(1'b1, 1'b0, 12'(12'h100 + n));
            chk($sformatf("wm_up%0d.usedw", n), 32'(ib.usedw), 32'(n));
            chk($sformatf("wm_up%0d.ae", n),    32'(ib.almost_empty), 32'(n <= 3));
            chk($sformatf("wm_up%0d.af", n),    32'(ib.almost_full), 32'(n >= 5));
            chk($sformatf("wm_up%0d.full", n),  32'(ib.full), 32'(n == 8));
            chk($sformatf("wm_up%0d.q", n),     32'(ib.q), 32'h101);
        end
        for (int n = 8; n >= 1; n--) begin
            chk($sformatf("wm_dn%0d.q", n), 32'(ib.q), 32'(12'(12'h100 + (9 - n))));
            b_cyc(1'b0, 1'b1, 12'h000);
            chk($sformatf("wm_dn%0d.usedw", n), 32'(ib.usedw), 32'(n - 1));
            chk($sformatf("wm_dn%0d.ae", n),    32'(ib.almost_empty), 32'((n - 1) <= 3));
            chk($sformatf("wm_dn%0d.af", n),    32'(ib.almost_full), 32'((n - 1) >= 5));
        end
        chk("wm.empty", 32'(ib.empty), 32'd1);
        chk("wm.ovf",   32'(ib.overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO; successor to the fixed 8-bit × 16 FIFO used in the Proyecto2 datapath. Width, depth and both watermark thresholds are set per instance. Adds a selectable show-ahead read mode, an almost-empty flag, an occupancy count that can represent full, and sticky overflow/underflow error flags. It sits between producer and consumer stages anywhere the design needs rate decoupling within one clock domain.

## Interface
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4
- AF_LEVEL, DEPTH-2, almost_full asserts when usedw ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when usedw ≤ AE_LEVEL (0..DEPTH-1)
- SHOW_AHEAD, 0, 0 = normal read mode (q registered after rdreq); 1 = show-ahead (q presents head word)

Let AW = log2(DEPTH).

- clock  in  1  rising-edge clock for all state
- aclr_n  in  1  asynchronous active-low reset
- sclr  in  1  synchronous clear, active high
- data  in  WIDTH  write data, sampled on an accepted write
- wrreq  in  1  write request
- rdreq  in  1  read request
- q  out  WIDTH  read data
- usedw  out  AW+1  number of stored words, 0..DEPTH
- empty  out  1  usedw == 0
- full  out  1  usedw == DEPTH
- almost_empty  out  1  usedw ≤ AE_LEVEL
- almost_full  out  1  usedw ≥ AF_LEVEL
- overflow  out  1  sticky: write attempted while full and not read in the same cycle
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH × WIDTH array, write pointer wp and read pointer rp (AW bits each, wrap modulo DEPTH), count register cnt (AW+1 bits) driven to usedw.
- Accept rules, evaluated on registered state at each rising edge:
  - rd_ok = rdreq & ~empty
  - wr_ok = wrreq & (~full | rdreq); a read and a write both succeed when full
  - Empty with both asserted: write accepted, read rejected, underflow set
- On wr_ok: mem[wp] ← data, wp ← wp+1. On rd_ok: rp ← rp+1.
- cnt: +1 on wr_ok only, −1 on rd_ok only, unchanged when both or neither.
- Flags are combinational decodes of cnt, so they change only after the clock edge that changes cnt.
- overflow sets on wrreq & full & ~rdreq; underflow sets on rdreq & empty. Both hold until sclr or aclr_n. A rejected request changes no other state.
- Normal mode (SHOW_AHEAD=0): on rd_ok, q ← mem[rp] at that edge; q holds its value otherwise, including while empty.
- Show-ahead mode (SHOW_AHEAD=1): q = mem[rp] continuously; rdreq acknowledges the head word and advances it. q is don't-care while empty=1.
- sclr=1: at the next edge wp, rp, cnt, overflow, underflow ← 0 and q (normal mode) ← 0. wrreq and rdreq are ignored in that cycle. Memory contents are not cleared.
- aclr_n=0: the same state clears immediately, without waiting for an edge. Reset mid-transfer discards all stored words. Release is synchronous to the design: the first edge after aclr_n rises may accept requests.

## Timing
- Reset values of all outputs: q=0, usedw=0, empty=1, full=0, almost_empty=1, almost_full=0 (when AF_LEVEL ≥ 1), overflow=0, underflow=0.
- Write-to-empty-deassert latency: 1 edge.
- Normal mode, read latency: rdreq high at edge N gives q valid after edge N. The earliest read of a word written at edge N is at edge N+1.
- Show-ahead mode: a word written into an empty FIFO at edge N appears on q after edge N, with empty=0.
- Sustained throughput is one write and one read per cycle at any occupancy, including full and one-below-empty.
- Pointer wrap from DEPTH-1 to 0 has no bubble.

## Test plan
- Reset and fill, defaults: assert aclr_n=0 mid-cycle and check outputs clear asynchronously. Write 0x56, 0xAA, 0xFF, 0xAA, then read 4 in normal mode. Required: q sequence 0x56, 0xAA, 0xFF, 0xAA, each one edge after its rdreq; usedw counts 1→4→0; empty=1 at the end.
- Full boundary, DEPTH=16: write 16 words (full=1 and almost_full=1 from usedw=14). Then write a 17th with rdreq=0. Required: overflow=1, usedw stays 16, and a subsequent drain returns words 0..15 unchanged.
- Simultaneous access: at full, assert wrreq and rdreq together for 20 cycles. Required: full stays 1, usedw=16, no overflow, and data stays in order across pointer wrap. At empty, assert both. Required: usedw→1, underflow=1.
- Show-ahead, SHOW_AHEAD=1, WIDTH=12, DEPTH=8: write 0xABC into empty. Required: q=0xABC after the same edge. A rdreq then advances q to the next word, or raises empty.
- Watermarks, AE_LEVEL=3, AF_LEVEL=5, DEPTH=8: step usedw 0→8→0. Required: almost_empty=1 for usedw ≤ 3 and almost_full=1 for usedw ≥ 5, each toggling exactly on the threshold edge.
- sclr with 6 words stored and wrreq=1: required usedw=0, empty=1, errors=0, q=0 after the edge, and the concurrent write discarded.
